// File: rtl/covert_symbol_tx.sv
// Frames preamble + host byte + guard symbol as on-off-keyed power-hog activity, one bit per SYMBOL_CYCLES.
// Optional noise dithering of the activity duty is enabled by defining COVERT_NOISE_DITHER_EN.
module covert_symbol_tx #(
  parameter int          SYMBOL_CYCLES = 1024,
  parameter logic [7:0]  PREAMBLE      = 8'hA5,
  parameter logic [3:0]  DUTY_HI       = 4'd14,
  parameter logic [3:0]  DUTY_LO       = 4'd2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] noise,
  input  logic [7:0]  tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic        act_en,
  output logic        bit_out,
  output logic        sym_strobe,
  output logic        busy
);

  localparam int             CW       = $clog2(SYMBOL_CYCLES);
  localparam logic [CW-1:0]  CNT_LAST = CW'(SYMBOL_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, PRE, DATA, GUARD} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    sym_idx;   // symbols sent in this part; bit position is 7 - sym_idx
  logic [7:0]    data_q;

  logic [2:0]    bit_pos;
  logic          cur_bit;
  logic          sym_last;
  logic          act_next;

  always_comb begin
    bit_pos = 3'd7 - sym_idx;
    cur_bit = 1'b0;
    case (state)
      PRE:     cur_bit = PREAMBLE[bit_pos];
      DATA:    cur_bit = data_q[bit_pos];
      default: cur_bit = 1'b0;
    endcase
    sym_last = (state != IDLE) && (cnt == CNT_LAST);
  end

`ifdef COVERT_NOISE_DITHER_EN
  logic unused_noise_hi;
  assign unused_noise_hi = ^noise[15:4];

  always_comb begin
    act_next = 1'b0;
    if (state == PRE || state == DATA)
      act_next = cur_bit ? (noise[3:0] < DUTY_HI) : (noise[3:0] < DUTY_LO);
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{noise, DUTY_HI, DUTY_LO};

  always_comb begin
    act_next = 1'b0;
    if (state == PRE || state == DATA)
      act_next = cur_bit;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      sym_idx <= 3'd0;
      data_q  <= 8'd0;
      act_en  <= 1'b0;
    end else begin
      act_en <= act_next;
      case (state)
        IDLE: begin
          if (tx_valid) begin
            data_q  <= tx_data;
            state   <= PRE;
            cnt     <= '0;
            sym_idx <= 3'd0;
          end
        end
        PRE, DATA: begin
          if (sym_last) begin
            cnt     <= '0;
            sym_idx <= sym_idx + 3'd1;
            if (sym_idx == 3'd7)
              state <= (state == PRE) ? DATA : GUARD;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        GUARD: begin
          if (sym_last) begin
            cnt     <= '0;
            sym_idx <= 3'd0;
            state   <= IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // All status outputs decode registered state only.
  assign tx_ready   = (state == IDLE);
  assign busy       = (state != IDLE);
  assign bit_out    = cur_bit;
  assign sym_strobe = sym_last;

endmodule

// File: tb/tb_covert_symbol_tx.sv
// Self-checking bench for covert_symbol_tx at SYMBOL_CYCLES=4 against a per-frame reference model.
module tb_covert_symbol_tx;

  localparam int SC     = 4;
  localparam int FRAME  = 17 * SC;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] noise;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        act_en;
  logic        bit_out;
  logic        sym_strobe;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  pre_byte = 8'hA5;
  logic [15:0] noise_hist [0:FRAME];

  covert_symbol_tx #(
    .SYMBOL_CYCLES(SC),
    .PREAMBLE(8'hA5),
    .DUTY_HI(4'd14),
    .DUTY_LO(4'd2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .noise(noise),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .act_en(act_en),
    .bit_out(bit_out),
    .sym_strobe(sym_strobe),
    .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time=%0t required below 200000", $time);
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] gen_noise(input int mode);
    case (mode)
      1:       return 16'h0005;
      2:       return 16'h000F;
      3:       return 16'h0000;
      default: return 16'($urandom);
    endcase
  endfunction

  // Logical symbol value for frame-relative observation k: 8 preamble bits, 8 data bits, guard.
  function automatic logic ref_bit(input logic [7:0] data, input int k);
    int sym;
    sym = k / SC;
    if (sym < 8)       return pre_byte[7 - sym];
    else if (sym < 16) return data[15 - sym];
    else               return 1'b0;
  endfunction

  function automatic logic ref_act(input logic b, input logic keyed, input logic [15:0] nz);
    if (!keyed) return 1'b0;
`ifdef COVERT_NOISE_DITHER_EN
    return b ? (nz[3:0] < 4'd14) : (nz[3:0] < 4'd2);
`else
    return b;
`endif
  endfunction

  task automatic start_frame(input logic [7:0] data, input int nmode);
    bit got = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tx_ready === 1'b1) begin
        got = 1;
        break;
      end
    end
    n_checks++;
    if (!got) begin
      n_fail++;
      $display("FAIL start_wait: tx_ready never rose, got %b required 1", tx_ready);
    end
    tx_valid = 1'b1;
    tx_data  = data;
    noise    = gen_noise(nmode);
  endtask

  // Observes ncyc cycles following an accept edge; observation 68 is the idle cycle after guard.
  task automatic check_frame(input logic [7:0] data, input int ncyc, input int nmode,
                             input logic dur_valid, input logic [7:0] dur_data,
                             input logic nxt_valid, input logic [7:0] nxt_data,
                             input string tag);
    int strobes = 0;
    int busy_cyc = 0;
    logic e_bit, e_busy, e_rdy, e_stb, e_act;
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk);
      e_busy = (k < FRAME);
      e_rdy  = (k == FRAME);
      e_bit  = (k < FRAME) ? ref_bit(data, k) : 1'b0;
      e_stb  = (k < FRAME) && ((k % SC) == SC - 1);
      e_act  = (k == 0) ? 1'b0 : ref_act(ref_bit(data, k - 1), (k - 1) < 16 * SC, noise_hist[k - 1]);
      if (sym_strobe === 1'b1) strobes++;
      if (busy === 1'b1) busy_cyc++;
      n_checks += 5;
      if (act_en !== e_act) begin
        n_fail++;
        $display("FAIL %s act_en k=%0d: got %b required %b", tag, k, act_en, e_act);
      end
      if (bit_out !== e_bit) begin
        n_fail++;
        $display("FAIL %s bit_out k=%0d: got %b required %b", tag, k, bit_out, e_bit);
      end
      if (busy !== e_busy) begin
        n_fail++;
        $display("FAIL %s busy k=%0d: got %b required %b", tag, k, busy, e_busy);
      end
      if (tx_ready !== e_rdy) begin
        n_fail++;
        $display("FAIL %s tx_ready k=%0d: got %b required %b", tag, k, tx_ready, e_rdy);
      end
      if (sym_strobe !== e_stb) begin
        n_fail++;
        $display("FAIL %s sym_strobe k=%0d: got %b required %b", tag, k, sym_strobe, e_stb);
      end
      noise = gen_noise(nmode);
      noise_hist[k] = noise;
      if (k == ncyc - 1) begin
        tx_valid = nxt_valid;
        tx_data  = nxt_data;
      end else begin
        tx_valid = dur_valid;
        tx_data  = dur_data;
      end
    end
    if (ncyc == FRAME + 1) begin
      n_checks += 2;
      if (strobes != 17) begin
        n_fail++;
        $display("FAIL %s strobe_count: got %0d required 17", tag, strobes);
      end
      if (busy_cyc != FRAME) begin
        n_fail++;
        $display("FAIL %s busy_cycles: got %0d required %0d", tag, busy_cyc, FRAME);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; tx_valid = 1'b1; tx_data = 8'h55; noise = 16'h0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks += 5;
      if (act_en !== 1'b0 || busy !== 1'b0 || sym_strobe !== 1'b0 || bit_out !== 1'b0 || tx_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_outputs: got act=%b busy=%b stb=%b bit=%b rdy=%b required 0 0 0 0 1",
                 act_en, busy, sym_strobe, bit_out, tx_ready);
      end
    end
    rst = 1'b0; tx_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_no_accept: busy got %b required 0", busy);
      end
    end
  endtask

  task automatic test_basic_frame();
    start_frame(8'h3C, 0);
    check_frame(8'h3C, FRAME + 1, 0, 1'b0, 8'h00, 1'b0, 8'h00, "basic_3c");
  endtask

  task automatic test_random_frames();
    logic [7:0] d;
    for (int i = 0; i < 4; i++) begin
      d = 8'($urandom);
      start_frame(d, 0);
      check_frame(d, FRAME + 1, 0, 1'b0, 8'h00, 1'b0, 8'h00, "random");
    end
  endtask

`ifdef COVERT_NOISE_DITHER_EN
  task automatic test_dither();
    for (int m = 1; m <= 3; m++) begin
      start_frame(8'hFF, m);
      check_frame(8'hFF, FRAME + 1, m, 1'b0, 8'h00, 1'b0, 8'h00, "dither");
    end
  endtask
`endif

  task automatic test_back_to_back();
    start_frame(8'h11, 0);
    check_frame(8'h11, FRAME + 1, 0, 1'b1, 8'h22, 1'b1, 8'h22, "b2b_first");
    check_frame(8'h22, FRAME + 1, 0, 1'b1, 8'h22, 1'b0, 8'h00, "b2b_second");
  endtask

  task automatic test_reset_mid_frame();
    start_frame(8'h3C, 0);
    check_frame(8'h3C, 10, 0, 1'b0, 8'h00, 1'b0, 8'h00, "abort_pre");
    rst = 1'b1;
    @(negedge clk);
    n_checks += 3;
    if (act_en !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_act_en: got %b required 0", act_en);
    end
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_busy: got %b required 0", busy);
    end
    if (tx_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_tx_ready: got %b required 1", tx_ready);
    end
    rst = 1'b0;
    start_frame(8'h81, 0);
    check_frame(8'h81, FRAME + 1, 0, 1'b0, 8'h00, 1'b0, 8'h00, "after_abort");
  endtask

  task automatic test_data_change_while_busy();
    start_frame(8'h3C, 0);
    check_frame(8'h3C, FRAME + 1, 0, 1'b1, 8'hC3, 1'b0, 8'hC3, "hold_3c");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0) begin
        n_fail++;
        $display("FAIL no_extra_frame: busy got %b required 0", busy);
      end
    end
  endtask

  initial begin
    rst = 1'b1; tx_valid = 1'b0; tx_data = 8'h00; noise = 16'h0;
    test_reset();
    test_basic_frame();
    test_random_frames();
`ifdef COVERT_NOISE_DITHER_EN
    test_dither();
`endif
    test_back_to_back();
    test_reset_mid_frame();
    test_data_change_while_busy();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
